// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: fixed-priority or round-robin grant with lock and conflict flag.
// Optional saturating conflict counter enabled by defining BUS_ARB_CONFLICT_CNT_EN.
module bus_source_arbiter #(
  parameter int N_SRC = 24,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  input  logic             rr_mode,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] fp_idx;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] scan_idx;
  logic             any_req;
  logic             multi_req;
  logic             hold;
  int               req_cnt;

  // Candidate grants for both modes are computed every cycle; rr_mode only picks one.
  always_comb begin
    fp_idx   = '0;
    rr_idx   = '0;
    scan_idx = '0;
    req_cnt  = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) fp_idx = SEL_W'(i);
      req_cnt = req_cnt + int'(req[i]);
    end
    // Walk from farthest to nearest so the first set bit below rr_ptr wins last.
    for (int k = N_SRC; k >= 1; k--) begin
      scan_idx = SEL_W'((int'(rr_ptr_q) + N_SRC - k) % N_SRC);
      if (req[scan_idx]) rr_idx = scan_idx;
    end
    any_req   = |req;
    multi_req = (req_cnt > 1);
  end

  assign hold = lock && valid_q && req[sel_q];

  always_comb begin
    sel_d      = sel_q;
    valid_d    = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    conflict_d = multi_req;
    if (hold) begin
      valid_d = 1'b1;
    end else if (any_req) begin
      valid_d = 1'b1;
      if (rr_mode) begin
        sel_d    = rr_idx;
        rr_ptr_d = rr_idx;
      end else begin
        sel_d = fp_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      rr_ptr_q   <= SEL_W'(N_SRC - 1);
    end else begin
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign conflict  = conflict_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate rather than wrap so a long burst of conflicts never reads as few.
  always_comb begin
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Table-driven scoreboard bench for bus_source_arbiter (N_SRC=24, SEL_W=5, CNT_W=2).
module tb_bus_source_arbiter;

  localparam int N_SRC = 24;
  localparam int SEL_W = 5;
  localparam int CNT_W = 2;
  localparam int NVEC  = 30;

  logic             clk;
  logic             clear;
  logic [N_SRC-1:0] req;
  logic             rr_mode;
  logic             lock;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  bus_source_arbiter #(.N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clock       (clk),
    .clear       (clear),
    .req         (req),
    .rr_mode     (rr_mode),
    .lock        (lock),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .conflict    (conflict),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             clr;
    logic [N_SRC-1:0] rq;
    logic             mode;
    logic             lk;
    logic [SEL_W-1:0] sel;
    logic             vld;
    logic             cf;
  } vec_t;

  typedef struct {
    string            name;
    logic [SEL_W-1:0] sel;
    logic             vld;
    logic             cf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t sb [$];
  int   nchk  = 0;
  int   npass = 0;
  int   mcnt  = 0;

  function automatic logic [N_SRC-1:0] bits(input int a, input int b, input int c);
    logic [N_SRC-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else npass++;
  endtask

  // Drive one cycle at the falling edge, queue the expectation, compare after the rising edge.
  task automatic step(input string nm, input logic c, input logic [N_SRC-1:0] r,
                      input logic m, input logic l, input logic [SEL_W-1:0] es,
                      input logic ev, input logic ecf, input logic [CNT_W-1:0] ecnt);
    exp_t e;
    @(negedge clk);
    clear = c; req = r; rr_mode = m; lock = l;
    e.name = nm; e.sel = es; e.vld = ev; e.cf = ecf; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_sel"},      32'(sel),          32'(e.sel));
      chk({e.name, "_valid"},    32'(sel_valid),    32'(e.vld));
      chk({e.name, "_conflict"}, 32'(conflict),     32'(e.cf));
      chk({e.name, "_cnt"},      32'(conflict_cnt), 32'(e.cnt));
    end
  endtask

  function automatic int cnt_model(input int cur, input logic c, input logic [N_SRC-1:0] r);
`ifdef BUS_ARB_CONFLICT_CNT_EN
    if (!c) return 0;
    if ($countones(r) > 1 && cur < (1 << CNT_W) - 1) return cur + 1;
    return cur;
`else
    return 0;
`endif
  endfunction

  initial begin
    logic [N_SRC-1:0] all1;
    logic [CNT_W-1:0] ec;
    all1 = '1;
    clear = 1'b0; req = '0; rr_mode = 1'b0; lock = 1'b0;

    //            clr  req                  mode  lock  sel  vld  cf
    tbl[0]  = '{1'b0, all1,                1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, all1,                1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, all1,                1'b0, 1'b0, 5'd23, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, bits(3, 21, -1),     1'b0, 1'b0, 5'd21, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, bits(3, -1, -1),     1'b0, 1'b0, 5'd3,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, '0,                  1'b0, 1'b0, 5'd3,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, '0,                  1'b0, 1'b1, 5'd3,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, '0,                  1'b0, 1'b1, 5'd0,  1'b0, 1'b0};
    tbl[8]  = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd20, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd7,  1'b1, 1'b1};
    tbl[10] = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd2,  1'b1, 1'b1};
    tbl[11] = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd20, 1'b1, 1'b1};
    tbl[12] = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd7,  1'b1, 1'b1};
    tbl[13] = '{1'b1, bits(7, 20, -1),     1'b1, 1'b1, 5'd7,  1'b1, 1'b1};
    tbl[14] = '{1'b1, bits(7, 20, -1),     1'b1, 1'b1, 5'd7,  1'b1, 1'b1};
    tbl[15] = '{1'b1, bits(7, 20, -1),     1'b1, 1'b1, 5'd7,  1'b1, 1'b1};
    tbl[16] = '{1'b1, bits(20, -1, -1),    1'b1, 1'b1, 5'd20, 1'b1, 1'b0};
    tbl[17] = '{1'b1, bits(7, 20, -1),     1'b1, 1'b1, 5'd20, 1'b1, 1'b1};
    tbl[18] = '{1'b0, bits(7, 20, -1),     1'b1, 1'b1, 5'd0,  1'b0, 1'b0};
    tbl[19] = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd20, 1'b1, 1'b1};
    tbl[20] = '{1'b1, bits(7, 22, -1),     1'b0, 1'b0, 5'd22, 1'b1, 1'b1};
    tbl[21] = '{1'b1, bits(2, 7, 20),      1'b1, 1'b0, 5'd7,  1'b1, 1'b1};
    tbl[22] = '{1'b1, bits(5, -1, -1),     1'b1, 1'b0, 5'd5,  1'b1, 1'b0};
    tbl[23] = '{1'b1, bits(5, -1, -1),     1'b1, 1'b0, 5'd5,  1'b1, 1'b0};
    tbl[24] = '{1'b1, bits(0, -1, -1),     1'b0, 1'b0, 5'd0,  1'b1, 1'b0};
    tbl[25] = '{1'b1, bits(0, 23, -1),     1'b0, 1'b0, 5'd23, 1'b1, 1'b1};
    tbl[26] = '{1'b1, bits(10, -1, -1),    1'b0, 1'b0, 5'd10, 1'b1, 1'b0};
    tbl[27] = '{1'b1, bits(10, 22, -1),    1'b0, 1'b1, 5'd10, 1'b1, 1'b1};
    tbl[28] = '{1'b1, bits(10, 22, -1),    1'b0, 1'b0, 5'd22, 1'b1, 1'b1};
    tbl[29] = '{1'b1, bits(22, -1, -1),    1'b0, 1'b1, 5'd22, 1'b1, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      mcnt = cnt_model(mcnt, tbl[i].clr, tbl[i].rq);
      step($sformatf("row%0d", i), tbl[i].clr, tbl[i].rq, tbl[i].mode, tbl[i].lk,
           tbl[i].sel, tbl[i].vld, tbl[i].cf, CNT_W'(mcnt));
    end

    // Counter saturation: five back-to-back conflicts after reset, then a clean cycle.
    step("sat_rst", 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
`ifdef BUS_ARB_CONFLICT_CNT_EN
      ec = (i < 2) ? CNT_W'(i + 1) : 2'd3;
`else
      ec = 2'd0;
`endif
      step($sformatf("sat%0d", i), 1'b1, bits(1, 2, -1), 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, ec);
    end
`ifdef BUS_ARB_CONFLICT_CNT_EN
    ec = 2'd3;
`else
    ec = 2'd0;
`endif
    step("sat_hold", 1'b1, bits(1, -1, -1), 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, ec);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
